mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit: signed/unsigned shift-add multiply and restoring
// divide, one iteration per clock, fixed latency of WIDTH+2 cycles per operation.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StFix} state_e;

    state_e            state_q;
    logic [1:0]        op_q;       // [1]: divide, [0]: unsigned
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  acc_q;      // upper product half / partial remainder
    logic [WIDTH-1:0]  mq_q;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]  mb_q;       // multiplicand / divisor magnitude
    logic [CntW-1:0]   cnt_q;
    logic              neg_lo_q;   // product or quotient must be negated
    logic              neg_hi_q;   // remainder must be negated

    logic              is_signed;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              b_zero;
    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    rem_shift;
    logic              rem_ge;
    logic [WIDTH-1:0]  acc_step, mq_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]  fix_hi, fix_lo;
    logic              last_iter;

    // Operand magnitudes for the PREP step.
    always_comb begin
        is_signed = ~op_q[0];
        a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        b_zero    = (b_q == '0);
        last_iter = (cnt_q == CntW'(WIDTH - 1));
    end

    // One CALC iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        add_sum   = {1'b0, acc_q} + {1'b0, mb_q};
        rem_shift = {acc_q, mq_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, mb_q});
        acc_step  = acc_q;
        mq_step   = mq_q;
        if (op_q[1]) begin
            // Result is below the divisor, so the low WIDTH bits of the difference suffice.
            acc_step = rem_ge ? (rem_shift[WIDTH-1:0] - mb_q) : rem_shift[WIDTH-1:0];
            mq_step  = {mq_q[WIDTH-2:0], rem_ge};
        end else if (mq_q[0]) begin
            acc_step = add_sum[WIDTH:1];
            mq_step  = {add_sum[0], mq_q[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[WIDTH-1:1]};
            mq_step  = {acc_q[0], mq_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = neg_lo_q ? -prod : prod;
        if (op_q[1]) begin
            fix_lo = neg_lo_q ? -mq_q : mq_q;
            fix_hi = neg_hi_q ? -acc_q : acc_q;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM with registered outputs and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        op_q    <= Op;
                        a_q     <= A;
                        b_q     <= B;
                        Busy    <= 1'b1;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    if (op_q[1] && b_zero) begin
                        // Divide by zero: report immediately, leave Hi/Lo untouched.
                        Done    <= 1'b1;
                        DivZero <= 1'b1;
                        Busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        mq_q     <= op_q[1] ? a_mag : b_mag;
                        mb_q     <= op_q[1] ? b_mag : a_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        neg_lo_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_hi_q <= is_signed & a_q[WIDTH-1];
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    mq_q  <= mq_step;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_iter) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    Hi      <= fix_hi;
                    Lo      <= fix_lo;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic         Clk = 1'b0;
    logic         Reset, Start;
    logic [1:0]   Op;
    logic [W-1:0] A, B;
    logic         Busy, Done, DivZero;
    logic [W-1:0] Hi, Lo;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference view of the last Hi/Lo result.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 Clk = ~Clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: plain language arithmetic; updates m_hi/m_lo, returns div-zero flag.
    task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit dz);
        logic signed [63:0] sa, sb, sres, srem;
        logic [63:0] ures;
        dz = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: begin sres = sa * sb; {m_hi, m_lo} = sres; end
            2'd1: begin ures = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = ures; end
            2'd2: begin
                if (b == 0) dz = 1'b1;
                else begin
                    sres = sa / sb;
                    srem = sa % sb;
                    m_lo = sres[W-1:0];
                    m_hi = srem[W-1:0];
                end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
    endtask

    // Issue one op from an IDLE cycle; returns cycles from acceptance edge to Done.
    // With noise set, junk Start pulses are driven while the op is in flight.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output int lat, output bit busy_bad);
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        lat = 0;
        busy_bad = (Busy !== 1'b1);
        while (lat < 60) begin
            Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            Op = 2'($urandom);
            A = $urandom;
            B = $urandom;
            tick();
            lat++;
            if (Done === 1'b1) break;
            if (Busy !== 1'b1) busy_bad = 1'b1;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; Op = 2'd1; A = 32'd5; B = 32'd6;
        tick();
        tick();
        Reset = 1'b0; Start = 1'b0;
        m_hi = '0; m_lo = '0;
        n_tests++;
        if ({Busy, Done, DivZero, Hi, Lo} !== {3'b000, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
                     Busy, Done, DivZero, Hi, Lo);
        end
        tick();
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_reset: got busy=%b done=%b, want 0 0", Busy, Done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]   ops [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        logic [W-1:0] as  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000};
        logic [W-1:0] bs  [4] = '{32'h00000007, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        logic [W-1:0] eh  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
        logic [W-1:0] el  [4] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000};
        int lat;
        bit bb, dz;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, lat, bb);
            model_op(ops[i], as[i], bs[i], dz);
            n_tests++;
            if (lat !== LAT) begin
                n_fail++;
                $display("FAIL directed%0d_latency: got %0d, want %0d", i, lat, LAT);
            end
            n_tests++;
            if ({DivZero, Hi, Lo} !== {1'b0, eh[i], el[i]}) begin
                n_fail++;
                $display("FAIL directed%0d_result: got dz=%b hi=%h lo=%h, want dz=0 hi=%h lo=%h",
                         i, DivZero, Hi, Lo, eh[i], el[i]);
            end
            n_tests++;
            if (bb || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed%0d_busy: got busy=%b busy_gap=%b, want 0 0", i, Busy, bb);
            end
            tick();
        end
    endtask

    task automatic test_divzero();
        int lat;
        bit bb, dz;
        // 0x3412 / 0x100 leaves Hi=0x12, Lo=0x34.
        run_op(2'd3, 32'h3412, 32'h100, 1'b0, lat, bb);
        model_op(2'd3, 32'h3412, 32'h100, dz);
        tick();
        run_op(2'd3, 32'd100, 32'd0, 1'b0, lat, bb);
        n_tests++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL divzero_latency: got %0d, want 1", lat);
        end
        n_tests++;
        if ({Done, DivZero, Busy, Hi, Lo} !== {3'b110, 32'h12, 32'h34}) begin
            n_fail++;
            $display("FAIL divzero_flags: got done=%b dz=%b busy=%b hi=%h lo=%h, want 1 1 0 12 34",
                     Done, DivZero, Busy, Hi, Lo);
        end
        tick();
        n_tests++;
        if (Done !== 1'b0 || DivZero !== 1'b0) begin
            n_fail++;
            $display("FAIL divzero_pulse: got done=%b dz=%b one cycle later, want 0 0",
                     Done, DivZero);
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b;
        int lat, exp_lat;
        bit bb, dz;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'h80000000;
                default: ;
            endcase
            run_op(op, a, b, 1'b1, lat, bb);
            model_op(op, a, b, dz);
            exp_lat = dz ? 1 : LAT;
            n_tests++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rand%0d_latency: op=%0d a=%h b=%h got %0d, want %0d",
                         i, op, a, b, lat, exp_lat);
            end
            n_tests++;
            if ({DivZero, Hi, Lo} !== {dz, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL rand%0d_result: op=%0d a=%h b=%h got dz=%b hi=%h lo=%h, want dz=%b hi=%h lo=%h",
                         i, op, a, b, DivZero, Hi, Lo, dz, m_hi, m_lo);
            end
            n_tests++;
            if (bb || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_busy: got busy=%b busy_gap=%b, want 0 0", i, Busy, bb);
            end
        end
        tick();
    endtask

    task automatic test_abort();
        bit busy_bad = 1'b0;
        bit done_seen = 1'b0;
        Start = 1'b1; Op = 2'd3; A = 32'd100; B = 32'd7;
        tick();
        busy_bad = (Busy !== 1'b1);
        for (int c = 1; c <= 10; c++) begin
            Start = (c == 5);
            Op = 2'd0;
            A = $urandom;
            B = $urandom;
            Reset = (c == 10);
            tick();
            if (Done === 1'b1) done_seen = 1'b1;
            if (c < 10 && Busy !== 1'b1) busy_bad = 1'b1;
        end
        Reset = 1'b0; Start = 1'b0;
        m_hi = '0; m_lo = '0;
        n_tests++;
        if (busy_bad) begin
            n_fail++;
            $display("FAIL abort_busy_before_reset: got busy dropped, want busy held");
        end
        n_tests++;
        if ({Busy, Hi, Lo} !== {1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL abort_reset_state: got busy=%b hi=%h lo=%h, want 0 0 0", Busy, Hi, Lo);
        end
        for (int c = 0; c < 50; c++) begin
            tick();
            if (Done === 1'b1 || Busy === 1'b1) done_seen = 1'b1;
        end
        n_tests++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL abort_no_done: got Done or Busy after abort, want neither");
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        bit bb1, bb2, dz;
        logic [W-1:0] hi1, lo1;
        run_op(2'd1, 32'd3, 32'd5, 1'b0, lat1, bb1);
        hi1 = Hi;
        lo1 = Lo;
        // Still in the Done cycle: the next op is requested right here.
        run_op(2'd3, 32'd17, 32'd5, 1'b0, lat2, bb2);
        model_op(2'd3, 32'd17, 32'd5, dz);
        n_tests++;
        if (lat1 !== LAT || {hi1, lo1} !== {32'd0, 32'd15}) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h, want %0d 0 f", lat1, hi1, lo1, LAT);
        end
        n_tests++;
        if (lat2 !== LAT || bb2) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got lat=%0d busy_gap=%b, want %0d 0", lat2, bb2, LAT);
        end
        n_tests++;
        if ({DivZero, Hi, Lo} !== {1'b0, 32'd2, 32'd3}) begin
            n_fail++;
            $display("FAIL b2b_second_result: got dz=%b hi=%h lo=%h, want 0 2 3", DivZero, Hi, Lo);
        end
        tick();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        tick();
        test_reset();
        test_directed();
        test_divzero();
        test_random();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
